// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_stage_pkg
// Purpose : Shared types and helpers for the memory stage: access-size enums,
//           the FSM state enum, the misalignment check and the byte-lane
//           helpers used for stores and loads (little-endian layout).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_BYTE = 2'b00,
    ST_HALF = 2'b01,
    ST_WORD = 2'b10,
    ST_RSVD = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    RT_LB  = 3'b000,
    RT_LH  = 3'b001,
    RT_LW  = 3'b010,
    RT_LBU = 3'b100,
    RT_LHU = 3'b101
  } read_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Access size: 0 byte, 1 half, 2 word. A store (including re&we) takes its
  // size from the store type; a pure load from the read type. A request with
  // neither re nor we touches nothing and therefore cannot be misaligned.
  function automatic logic is_misaligned(input logic re, input logic we,
                                         input logic [1:0] st, input logic [2:0] rt,
                                         input logic [1:0] off);
    logic [1:0] size;
    size = 2'd2;
    if (we) begin
      if (st == ST_BYTE)      size = 2'd0;
      else if (st == ST_HALF) size = 2'd1;
    end else if (re) begin
      if (rt == RT_LB || rt == RT_LBU)      size = 2'd0;
      else if (rt == RT_LH || rt == RT_LHU) size = 2'd1;
    end else begin
      return 1'b0;
    end
    if (size == 2'd1) return off[0];
    if (size == 2'd2) return (off != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
    if (st == ST_BYTE) return 4'b0001 << off;
    if (st == ST_HALF) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Replicate narrow data across all lanes so the byte enables pick the lane.
  function automatic logic [31:0] store_lanes(input logic [1:0] st, input logic [31:0] d);
    if (st == ST_BYTE) return {4{d[7:0]}};
    if (st == ST_HALF) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0] off,
                                               input logic [2:0] rt);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? word[31:16] : word[15:0];
    case (rt)
      RT_LB:   return {{24{b[7]}}, b};
      RT_LBU:  return {24'h0, b};
      RT_LH:   return {{16{h[15]}}, h};
      RT_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_array
// Purpose : DEPTH_WORDS x 32 storage, clocked byte-enable write, word read.
//           Contents are deliberately not reset.
// Ports   : clk   - clock
//           we    - write strobe, be - byte enables (bit n = bits 8n+7:8n)
//           idx   - word index shared by read and write
//           wdata - write data, rdata - word at idx
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  // Read is combinational so a load and the store-commit edge both see the
  // array at the same address in the cycle that enters RESP.
  assign rdata = mem[idx];

endmodule
`default_nettype wire

// File: rtl/mem_stage_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_stage_unit
// Purpose : Load/store memory stage with valid/ready request handshake,
//           configurable response latency, misalignment detection and the
//           branch take-select.
// Ports   : clk, rst (async, active high)
//           req_valid/req_ready - request handshake
//           mem_re, mem_we, mem_store_type, mem_read_type, d_in, addr - request
//           branch, branch_flag -> pc_src (combinational)
//           resp_valid, d_out, misalign_err - response
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [1:0]        mem_store_type,
  input  logic [2:0]        mem_read_type,
  input  logic [31:0]       d_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              branch,
  input  logic              branch_flag,
  output logic              pc_src,
  output logic              resp_valid,
  output logic [31:0]       d_out,
  output logic              misalign_err
);

  localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
  localparam logic       c_zero_lat = (LATENCY == 0);
  localparam logic [3:0] c_cnt_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                re_q, re_d, we_q, we_d;
  logic [1:0]          st_q, st_d;
  logic [2:0]          rt_q, rt_d;
  logic [31:0]         dout_q, dout_d;
  logic                err_q, err_d;

  // Effective request: live inputs while idle (needed when RESP is entered on
  // the acceptance edge itself), registered copy afterwards.
  logic                eff_re, eff_we, mis, enter_resp, arr_we;
  logic [1:0]          eff_st;
  logic [2:0]          eff_rt;
  logic [31:0]         eff_din, rdata;
  logic [ADDR_W-1:0]   eff_addr;
  logic [c_idx_w-1:0]  word_idx;

  assign pc_src       = branch & branch_flag;
  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign misalign_err = (state_q == S_RESP) & err_q;
  assign d_out        = dout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    re_d       = re_q;
    we_d       = we_q;
    st_d       = st_q;
    rt_d       = rt_q;
    dout_d     = dout_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    if (state_q == S_IDLE) begin
      eff_addr = addr;  eff_din = d_in;  eff_re = mem_re;  eff_we = mem_we;
      eff_st   = mem_store_type;  eff_rt = mem_read_type;
    end else begin
      eff_addr = addr_q;  eff_din = din_q;  eff_re = re_q;  eff_we = we_q;
      eff_st   = st_q;  eff_rt = rt_q;
    end
    mis = is_misaligned(eff_re, eff_we, eff_st, eff_rt, eff_addr[1:0]);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = addr;  din_d = d_in;  re_d = mem_re;  we_d = mem_we;
          st_d   = mem_store_type;  rt_d = mem_read_type;
          if (c_zero_lat || mis) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = c_cnt_init;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Only a pure, aligned load returns data; stores (incl. re&we), no-ops
    // and faults all respond with zero.
    if (enter_resp) begin
      err_d  = mis;
      dout_d = (eff_re && !eff_we && !mis) ? load_extract(rdata, eff_addr[1:0], eff_rt)
                                           : 32'h0;
    end

    arr_we   = enter_resp && eff_we && !mis;
    // Truncation gives the modulo-DEPTH_WORDS wrap of the word address.
    word_idx = c_idx_w'(eff_addr >> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      din_q   <= 32'h0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      st_q    <= 2'b00;
      rt_q    <= 3'b000;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      re_q    <= re_d;
      we_q    <= we_d;
      st_q    <= st_d;
      rt_q    <= rt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (c_idx_w)
  ) u_mem_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (store_be(eff_st, eff_addr[1:0])),
    .idx  (word_idx),
    .wdata(store_lanes(eff_st, eff_din)),
    .rdata(rdata)
  );

endmodule
`default_nettype wire

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Parameters
REQ-001 Parameter ADDR_W: default 16; byte-address width.
REQ-002 Parameter DEPTH_WORDS: default 1024; number of 32-bit words in the internal array, power of two.
REQ-003 Parameter LATENCY: default 2; wait cycles between accept and response, range 0..15.

Interface
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 mem_re  in  1  load request.
REQ-009 mem_we  in  1  store request.
REQ-010 mem_store_type  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-011 mem_read_type  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes treated as lw.
REQ-012 d_in  in  32  store data, LSB-aligned.
REQ-013 addr  in  ADDR_W  byte address.
REQ-014 branch  in  1  branch instruction flag.
REQ-015 branch_flag  in  1  branch condition true.
REQ-016 pc_src  out  1  take-branch select.
REQ-017 resp_valid  out  1  one-cycle response strobe.
REQ-018 d_out  out  32  load result, held until next response.
REQ-019 misalign_err  out  1  response carried a misalignment fault, valid with resp_valid.

Function
REQ-020 pc_src SHALL equal branch AND branch_flag combinationally, independent of the FSM and reset.
REQ-021 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 A request is accepted on a cycle with req_valid=1 and req_ready=1; addr, d_in, and type fields SHALL be registered at acceptance.
REQ-023 On acceptance: LATENCY=0 or misaligned -> go to RESP; otherwise go to WAIT with a counter loaded with LATENCY-1.
REQ-024 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 0, so resp_valid rises LATENCY+1 cycles after acceptance.
REQ-025 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE, so back-to-back requests are spaced LATENCY+2 cycles apart.
REQ-026 Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0. Response after 1 cycle with misalign_err=1 and d_out=0; no array write.
REQ-027 Store commits on the edge entering RESP using byte enables from addr[1:0] and the store type. Layout is little-endian.
REQ-028 Load data SHALL be captured on the edge entering RESP. The byte or half at addr[1:0] is sign- or zero-extended per mem_read_type.
REQ-029 mem_re=1 and mem_we=1 together SHALL be treated as a store, and d_out=0.
REQ-030 mem_re=0 and mem_we=0 SHALL still complete the handshake, with d_out=0 and no array access.
REQ-031 Word index is addr[ADDR_W-1:2] modulo DEPTH_WORDS; out-of-range addresses wrap without error.
REQ-032 A store followed by a load to the same word SHALL return the stored data; no stale read is permitted.

Reset
REQ-033 rst=1 SHALL force state IDLE, counter 0, req_ready=1, resp_valid=0, misalign_err=0, d_out=0.
REQ-034 Reset during WAIT SHALL abort the transaction: no array write and no response.
REQ-035 Array contents SHALL NOT be reset.

Structure
REQ-036 Package mem_stage_pkg SHALL hold the store_type and read_type enums, the FSM state enum, and the misalignment-check function.
REQ-037 Sub-module mem_array SHALL be a DEPTH_WORDS x 32 synchronous array with 4-bit byte-enable write and word read.

Verification
REQ-038 Bench SHALL cover these scenarios:
- LATENCY=2: sw 0xDEADBEEF to 0x0010, then lw 0x0010 -> resp_valid 3 cycles after each accept, d_out=0xDEADBEEF.
- sb 0x80 to 0x0013, then lb 0x0013 -> 0xFFFFFF80; lbu 0x0013 -> 0x00000080; lw 0x0010 -> 0x80ADBEEF.
- lh at 0x0011 -> misalign_err=1, d_out=0, response 1 cycle after accept; array unchanged.
- rst pulse during WAIT of sw 0x12345678 to 0x0020 -> no resp_valid; later lw 0x0020 returns the prior contents.
- ADDR_W=16, DEPTH_WORDS=1024: sw to 0x1004, then lw 0x0004 -> same data (wrap).
- branch=1, branch_flag=1 -> pc_src=1 the same cycle, including during rst; any other combination -> pc_src=0.
